// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the MEM stage / load-store unit.
// Lane helpers assume 4 byte lanes per word (lane = address[1:0]).
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Reserved size 2'b11 behaves as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return (lane != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/ram_datos_be.sv
// Byte-enable data RAM: synchronous write, asynchronous read and debug read ports.
// No reset, so contents survive a pipeline reset.
module ram_datos_be #(
  parameter int unsigned LEN     = 32,
  parameter int unsigned NB_ADDR = 11,
  parameter int unsigned NB_COL  = LEN / 8
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [NB_COL-1:0]  i_be,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [LEN-1:0]     i_wdata,
  output logic [LEN-1:0]     o_rdata,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [LEN-1:0]     o_dbg_data
);

  logic [LEN-1:0] mem [2**NB_ADDR];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int c = 0; c < NB_COL; c++) begin
        if (i_be[c]) mem[i_addr][c*8 +: 8] <= i_wdata[c*8 +: 8];
      end
    end
  end

  assign o_rdata    = mem[i_addr];
  assign o_dbg_data = mem[i_dbg_addr];

endmodule

// File: rtl/mem_stage_lsu.sv
// MIPS MEM stage: byte/half/word load-store with wait-state stall, MEM/WB
// pipeline register and branch resolution.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int unsigned LEN                  = 32,
  parameter int unsigned NB_ADDR              = 11,
  parameter int unsigned NB_CTRL_WB           = 2,
  parameter int unsigned NB_ADDRESS_REGISTROS = 5,
  parameter int unsigned WAIT_STATES          = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  input  logic [LEN-1:0]                  i_address,
  input  logic [LEN-1:0]                  i_write_data,
  input  logic                            i_mem_read,
  input  logic                            i_mem_write,
  input  logic [1:0]                      i_size,
  input  logic                            i_unsigned,
  input  logic                            i_branch,
  input  logic                            i_branch_ne,
  input  logic                            i_alu_zero,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_ADDR-1:0]              i_dbg_addr,
  output logic                            o_stall,
  output logic                            o_pcsrc,
  output logic                            o_valid,
  output logic [LEN-1:0]                  o_address,
  output logic [LEN-1:0]                  o_read_data,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
  output logic                            o_misaligned,
  output logic [LEN-1:0]                  o_dbg_data
);

  localparam int unsigned NB_COL    = LEN / 8;
  localparam bit          HAS_WAIT  = (WAIT_STATES != 0);
  localparam logic [3:0]  CNT_LOAD  = 4'(WAIT_STATES - 1);

  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  logic               is_store, is_load, misaligned, aligned_access;
  logic [NB_COL-1:0]  be;
  logic [LEN-1:0]     store_data, rd_word, load_data;
  logic               we, commit;
  logic               unused_addr;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  assign word_idx    = i_address[NB_ADDR+1:2];
  assign lane        = i_address[1:0];
  assign unused_addr = ^i_address[LEN-1:NB_ADDR+2];

  // Read+write together is a store.
  assign is_store       = i_valid & i_mem_write;
  assign is_load        = i_valid & i_mem_read & ~i_mem_write;
  assign misaligned     = (is_store | is_load) & is_misaligned(i_size, lane);
  assign aligned_access = (is_store | is_load) & ~misaligned;

  always_comb begin
    be         = NB_COL'(lane_be(i_size, lane));
    store_data = i_write_data;
    case (i_size)
      SZ_BYTE: store_data = {NB_COL{i_write_data[7:0]}};
      SZ_HALF: store_data = {(NB_COL/2){i_write_data[15:0]}};
      default: be = '1;
    endcase
  end

  assign load_data = LEN'(lane_extract(rd_word[31:0], i_size, lane, i_unsigned));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_stall = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (aligned_access && HAS_WAIT) begin
          o_stall = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end else begin
          commit = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          o_stall = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset gates the write so an aborted wait never lands in the RAM.
  assign we = i_rst & commit & aligned_access & is_store;

  ram_datos_be #(
    .LEN     (LEN),
    .NB_ADDR (NB_ADDR),
    .NB_COL  (NB_COL)
  ) u_ram (
    .i_clk      (i_clk),
    .i_we       (we),
    .i_be       (be),
    .i_addr     (word_idx),
    .i_wdata    (store_data),
    .o_rdata    (rd_word),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_valid      <= 1'b0;
      o_address    <= '0;
      o_read_data  <= '0;
      o_write_reg  <= '0;
      o_ctrl_wb    <= '0;
      o_misaligned <= 1'b0;
    end else if (commit) begin
      o_valid      <= i_valid;
      o_address    <= i_address;
      o_read_data  <= (is_load && !misaligned) ? load_data : '0;
      o_write_reg  <= i_write_reg;
      o_ctrl_wb    <= misaligned ? '0 : i_ctrl_wb;
      o_misaligned <= misaligned;
    end else begin
      o_valid      <= 1'b0;
      o_ctrl_wb    <= '0;
      o_misaligned <= 1'b0;
    end
  end

  assign o_pcsrc = i_valid & i_branch & (i_branch_ne ? ~i_alu_zero : i_alu_zero);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench: vector table against a zero-wait instance, hand sequences
// against a three-wait-state instance (stall timing, reset abort, branch).
module tb_mem_stage_lsu;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;
  localparam int NV = 21;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid, i_mem_read, i_mem_write, i_unsigned;
  logic        i_branch, i_branch_ne, i_alu_zero;
  logic [31:0] i_address, i_write_data;
  logic [1:0]  i_size, i_ctrl_wb;
  logic [4:0]  i_write_reg;
  logic [10:0] i_dbg_addr;

  logic        stall0, pcsrc0, valid0, mis0, stall3, pcsrc3, valid3, mis3;
  logic [31:0] addr0, rdata0, dbg0, addr3, rdata3, dbg3;
  logic [4:0]  wreg0, wreg3;
  logic [1:0]  ctrl0, ctrl3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_address(i_address),
    .i_write_data(i_write_data), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_branch(i_branch),
    .i_branch_ne(i_branch_ne), .i_alu_zero(i_alu_zero), .i_write_reg(i_write_reg),
    .i_ctrl_wb(i_ctrl_wb), .i_dbg_addr(i_dbg_addr), .o_stall(stall0), .o_pcsrc(pcsrc0),
    .o_valid(valid0), .o_address(addr0), .o_read_data(rdata0), .o_write_reg(wreg0),
    .o_ctrl_wb(ctrl0), .o_misaligned(mis0), .o_dbg_data(dbg0)
  );

  mem_stage_lsu #(.WAIT_STATES(3)) dut3 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_address(i_address),
    .i_write_data(i_write_data), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_branch(i_branch),
    .i_branch_ne(i_branch_ne), .i_alu_zero(i_alu_zero), .i_write_reg(i_write_reg),
    .i_ctrl_wb(i_ctrl_wb), .i_dbg_addr(i_dbg_addr), .o_stall(stall3), .o_pcsrc(pcsrc3),
    .o_valid(valid3), .o_address(addr3), .o_read_data(rdata3), .o_write_reg(wreg3),
    .o_ctrl_wb(ctrl3), .o_misaligned(mis3), .o_dbg_data(dbg3)
  );

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic [10:0] dbg;
    logic [31:0] exp_dbg;
  } vec_t;

  vec_t vt[NV];

  function automatic vec_t mk(input logic v, input logic [31:0] a, input logic [31:0] wd,
                              input logic rd, input logic wr, input logic [1:0] sz,
                              input logic u, input logic c, input logic [31:0] er,
                              input logic em, input logic [10:0] dbg,
                              input logic [31:0] ed);
    vec_t r;
    r.valid = v; r.addr = a; r.wdata = wd; r.rd = rd; r.wr = wr; r.size = sz; r.uns = u;
    r.chk_rd = c; r.exp_rd = er; r.exp_mis = em; r.dbg = dbg; r.exp_dbg = ed;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic [1:0] sz, input logic u);
    i_valid = v; i_address = a; i_write_data = wd; i_mem_read = rd; i_mem_write = wr;
    i_size = sz; i_unsigned = u;
  endtask

  task automatic set_idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, W, 1'b0);
    i_branch = 1'b0; i_branch_ne = 1'b0; i_alu_zero = 1'b0;
  endtask

  // Presentation cycle, then three stall cycles expected on the wait-state instance.
  task automatic wait3_access(input string name);
    for (int c = 0; c < 4; c++) begin
      check({name, "_stall"}, {31'h0, stall3}, {31'h0, c < 3});
      check({name, "_valid_low"}, {31'h0, valid3}, 32'h0);
      @(posedge clk); #1;
    end
    check({name, "_valid"}, {31'h0, valid3}, 32'h1);
  endtask

  initial begin
    vt[0]  = mk(1, 32'h10,   32'h0,        0, 1, W, 0, 0, 0,            0, 11'd4, 32'h0);
    vt[1]  = mk(1, 32'h13,   32'hA5,       0, 1, B, 0, 0, 0,            0, 11'd4, 32'hA5000000);
    vt[2]  = mk(1, 32'h13,   32'h0,        1, 0, B, 0, 1, 32'hFFFFFFA5, 0, 11'd4, 32'hA5000000);
    vt[3]  = mk(1, 32'h13,   32'h0,        1, 0, B, 1, 1, 32'h000000A5, 0, 11'd4, 32'hA5000000);
    vt[4]  = mk(1, 32'h20,   32'h0,        0, 1, W, 0, 0, 0,            0, 11'd8, 32'h0);
    vt[5]  = mk(1, 32'h22,   32'h8001,     0, 1, H, 0, 0, 0,            0, 11'd8, 32'h80010000);
    vt[6]  = mk(1, 32'h22,   32'h0,        1, 0, H, 1, 1, 32'h00008001, 0, 11'd8, 32'h80010000);
    vt[7]  = mk(1, 32'h22,   32'h0,        1, 0, H, 0, 1, 32'hFFFF8001, 0, 11'd8, 32'h80010000);
    vt[8]  = mk(1, 32'h04,   32'h0BADF00D, 0, 1, W, 0, 0, 0,            0, 11'd1, 32'h0BADF00D);
    vt[9]  = mk(1, 32'h06,   32'h0,        1, 0, W, 0, 0, 0,            1, 11'd1, 32'h0BADF00D);
    vt[10] = mk(1, 32'h06,   32'hFFFFFFFF, 0, 1, W, 0, 0, 0,            1, 11'd1, 32'h0BADF00D);
    vt[11] = mk(1, 32'h21,   32'h7777,     0, 1, H, 0, 0, 0,            1, 11'd8, 32'h80010000);
    vt[12] = mk(1, 32'h20,   32'h1234565A, 0, 1, B, 0, 0, 0,            0, 11'd8, 32'h8001005A);
    vt[13] = mk(1, 32'h23,   32'h0,        1, 0, B, 0, 1, 32'hFFFFFF80, 0, 11'd8, 32'h8001005A);
    vt[14] = mk(1, 32'h22,   32'h0,        1, 0, B, 0, 1, 32'h00000001, 0, 11'd8, 32'h8001005A);
    vt[15] = mk(1, 32'h20,   32'h0,        1, 0, R, 0, 1, 32'h8001005A, 0, 11'd8, 32'h8001005A);
    vt[16] = mk(1, 32'h1234, 32'h0,        0, 0, W, 0, 0, 0,            0, 11'd8, 32'h8001005A);
    vt[17] = mk(0, 32'h5678, 32'h0,        0, 0, W, 0, 0, 0,            0, 11'd8, 32'h8001005A);
    vt[18] = mk(1, 32'h21,   32'h33,       1, 1, B, 0, 0, 0,            0, 11'd8, 32'h8001335A);
    vt[19] = mk(1, 32'h2020, 32'hCAFEF00D, 0, 1, W, 0, 0, 0,            0, 11'd8, 32'hCAFEF00D);
    vt[20] = mk(1, 32'h20,   32'h0,        1, 0, W, 0, 1, 32'hCAFEF00D, 0, 11'd8, 32'hCAFEF00D);

    i_rst = 1'b0; set_idle();
    i_write_reg = 5'd0; i_ctrl_wb = 2'b10; i_dbg_addr = 11'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, valid0}, 32'h0);
    check("rst_addr", addr0, 32'h0);
    check("rst_ctrl", {30'h0, ctrl0}, 32'h0);
    check("rst_stall", {31'h0, stall3}, 32'h0);
    i_rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].valid, vt[i].addr, vt[i].wdata, vt[i].rd, vt[i].wr, vt[i].size, vt[i].uns);
      i_write_reg = 5'(i + 1);
      i_dbg_addr  = vt[i].dbg;
      #1;
      check($sformatf("v%0d_stall", i), {31'h0, stall0}, 32'h0);
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), {31'h0, valid0}, {31'h0, vt[i].valid});
      check($sformatf("v%0d_addr", i), addr0, vt[i].addr);
      check($sformatf("v%0d_wreg", i), {27'h0, wreg0}, i + 1);
      check($sformatf("v%0d_mis", i), {31'h0, mis0}, {31'h0, vt[i].exp_mis});
      check($sformatf("v%0d_ctrl", i), {30'h0, ctrl0}, vt[i].exp_mis ? 32'h0 : 32'h2);
      check($sformatf("v%0d_dbg", i), dbg0, vt[i].exp_dbg);
      if (vt[i].chk_rd) check($sformatf("v%0d_rdata", i), rdata0, vt[i].exp_rd);
    end

    // Clean start for the wait-state instance.
    set_idle(); i_rst = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b1;

    i_dbg_addr = 11'd16; i_write_reg = 5'd9;
    drive(1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b1, W, 1'b0);
    #1;
    wait3_access("sw3");
    check("sw3_addr", addr3, 32'h40);
    check("sw3_dbg", dbg3, 32'hDEADBEEF);
    set_idle();

    // Reset in the second stall cycle aborts the store.
    drive(1'b1, 32'h40, 32'h12345678, 1'b0, 1'b1, W, 1'b0);
    #1;
    check("abort_stall0", {31'h0, stall3}, 32'h1);
    @(posedge clk); #1;
    check("abort_stall1", {31'h0, stall3}, 32'h1);
    i_rst = 1'b0; set_idle();
    @(posedge clk); #1;
    check("abort_valid", {31'h0, valid3}, 32'h0);
    check("abort_addr", addr3, 32'h0);
    check("abort_wreg", {27'h0, wreg3}, 32'h0);
    check("abort_ctrl", {30'h0, ctrl3}, 32'h0);
    check("abort_mis", {31'h0, mis3}, 32'h0);
    check("abort_stall", {31'h0, stall3}, 32'h0);
    check("abort_dbg", dbg3, 32'hDEADBEEF);
    i_rst = 1'b1;

    drive(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, W, 1'b0);
    #1;
    wait3_access("lw3");
    check("lw3_rdata", rdata3, 32'hDEADBEEF);
    check("lw3_ctrl", {30'h0, ctrl3}, 32'h2);
    set_idle();

    drive(1'b1, 32'h42, 32'h0, 1'b1, 1'b0, W, 1'b0);
    #1;
    check("mis3_stall", {31'h0, stall3}, 32'h0);
    @(posedge clk); #1;
    check("mis3_flag", {31'h0, mis3}, 32'h1);
    check("mis3_valid", {31'h0, valid3}, 32'h1);
    check("mis3_ctrl", {30'h0, ctrl3}, 32'h0);
    set_idle();

    i_valid = 1'b1; i_branch = 1'b1; i_branch_ne = 1'b1; i_alu_zero = 1'b0;
    #1; check("pcsrc_bne_taken", {31'h0, pcsrc0}, 32'h1);
    i_valid = 1'b0;
    #1; check("pcsrc_invalid", {31'h0, pcsrc0}, 32'h0);
    i_valid = 1'b1; i_alu_zero = 1'b1;
    #1; check("pcsrc_bne_not", {31'h0, pcsrc0}, 32'h0);
    i_branch_ne = 1'b0;
    #1; check("pcsrc_beq_taken", {31'h0, pcsrc0}, 32'h1);
    i_alu_zero = 1'b0;
    #1; check("pcsrc_beq_not", {31'h0, pcsrc0}, 32'h0);
    i_branch = 1'b0; i_alu_zero = 1'b1;
    #1; check("pcsrc_nobranch", {31'h0, pcsrc0}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
